// File: rtl/debounce_pkg.sv
// Shared types and constants for the switch debouncer.
package debounce_pkg;

    // Debounce FSM states. Rise = WAIT1_k, Fall = WAIT0_k.
    typedef enum logic [2:0] {
        StZero,
        StRise1,
        StRise2,
        StRise3,
        StOne,
        StFall1,
        StFall2,
        StFall3
    } state_t;

    // Number of counter ticks a changed level must survive before it is accepted.
    localparam int unsigned CONFIRM_TICKS = 3;

endpackage

// File: rtl/debounce_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module debounce_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the raw level through two flops to settle metastability.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/debounce.sv
// Mechanical-switch debouncer: clean level plus a one-cycle pulse on each confirmed press.
module debounce
    import debounce_pkg::*;
#(
    parameter int unsigned N = 19
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic db_tick
);

    logic         sw_s;
    logic [N-1:0] cnt_q, cnt_d;
    logic         m_tick;
    state_t       state_q, state_d;
    logic         db_level_q, db_level_d;

    debounce_sync2 u_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (sw),
        .q_o    (sw_s)
    );

    // Free-running tick counter; a tick is the cycle where it reads zero.
    always_comb begin
        cnt_d = cnt_q + N'(1);
    end

    assign m_tick = (cnt_q == '0);

    // Confirmation FSM: a reversal always wins over a tick and drops back to the stable state.
    always_comb begin
        state_d = state_q;
        db_tick = 1'b0;
        unique case (state_q)
            StZero:  if (sw_s) state_d = StRise1;
            StRise1: begin
                if (!sw_s)       state_d = StZero;
                else if (m_tick) state_d = StRise2;
            end
            StRise2: begin
                if (!sw_s)       state_d = StZero;
                else if (m_tick) state_d = StRise3;
            end
            StRise3: begin
                if (!sw_s) begin
                    state_d = StZero;
                end else if (m_tick) begin
                    state_d = StOne;
                    db_tick = 1'b1;
                end
            end
            StOne:   if (!sw_s) state_d = StFall1;
            StFall1: begin
                if (sw_s)        state_d = StOne;
                else if (m_tick) state_d = StFall2;
            end
            StFall2: begin
                if (sw_s)        state_d = StOne;
                else if (m_tick) state_d = StFall3;
            end
            StFall3: begin
                if (sw_s)        state_d = StOne;
                else if (m_tick) state_d = StZero;
            end
        endcase
    end

    // Level is high in the stable-one state and while a release is still unconfirmed.
    always_comb begin
        db_level_d = (state_d == StOne)   || (state_d == StFall1) ||
                     (state_d == StFall2) || (state_d == StFall3);
    end

    // State, counter and registered level; reset forces everything low immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            state_q    <= StZero;
            db_level_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            db_level_q <= db_level_d;
        end
    end

    assign db_level = db_level_q;

endmodule

// File: tb/tb_debounce.sv
// Self-checking bench for debounce (N=4) against a behavioural confirmation model.
module tb_debounce;

    localparam int unsigned N      = 4;
    localparam int          PERIOD = 1 << N;
    localparam int          NCONF  = 3;

    logic clk;
    logic reset;
    logic sw;
    logic db_level;
    logic db_tick;

    int n_checks;
    int n_errors;

    debounce #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .db_level (db_level),
        .db_tick  (db_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: accepted level, whether a change is pending, ticks seen so far,
    // the input as seen two cycles late, and elapsed cycles since reset.
    logic m_s1, m_s2, m_lvl, m_pend;
    int   m_cnt;
    int   m_cyc;
    logic exp_tick;

    assign exp_tick = !m_lvl && m_pend && (m_cnt == NCONF - 1) && m_s2 &&
                      ((m_cyc % PERIOD) == 0);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_s1   <= 1'b0;
            m_s2   <= 1'b0;
            m_lvl  <= 1'b0;
            m_pend <= 1'b0;
            m_cnt  <= 0;
            m_cyc  <= 0;
        end else begin
            m_s1  <= sw;
            m_s2  <= m_s1;
            m_cyc <= m_cyc + 1;
            if (!m_pend) begin
                if (m_s2 != m_lvl) begin
                    m_pend <= 1'b1;
                    m_cnt  <= 0;
                end
            end else if (m_s2 == m_lvl) begin
                m_pend <= 1'b0;
            end else if ((m_cyc % PERIOD) == 0) begin
                if (m_cnt == NCONF - 1) begin
                    m_lvl  <= m_s2;
                    m_pend <= 1'b0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        sw    = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (db_level !== 1'b0 || db_tick !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_hold: level=%b tick=%b expected level=0 tick=0",
                         db_level, db_tick);
            end
        end
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if (db_level !== 1'b0 || db_tick !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_release: level=%b tick=%b expected level=0 tick=0",
                         db_level, db_tick);
            end
        end
    endtask

    // Drive a clean edge and hold; measure when the level settles and count pulses.
    task automatic test_edge(input logic val, input string name);
        int ticks;
        int change;
        ticks  = 0;
        change = -1;
        sw     = val;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            n_checks++;
            if (db_level !== m_lvl || db_tick !== exp_tick) begin
                n_errors++;
                $display("FAIL %s cyc %0d: level=%b tick=%b expected level=%b tick=%b",
                         name, i, db_level, db_tick, m_lvl, exp_tick);
            end
            if (db_tick === 1'b1) ticks++;
            if (db_level === val && change < 0) change = i;
        end
        n_checks++;
        if (ticks != (val ? 1 : 0)) begin
            n_errors++;
            $display("FAIL %s_ticks: got %0d expected %0d", name, ticks, val ? 1 : 0);
        end
        n_checks++;
        if (change < 35 || change > 51) begin
            n_errors++;
            $display("FAIL %s_latency: got %0d cycles expected 35..51", name, change);
        end
        n_checks++;
        if (db_level !== val) begin
            n_errors++;
            $display("FAIL %s_final: level=%b expected %b", name, db_level, val);
        end
    endtask

    task automatic test_bounce();
        logic pat [4];
        int   ticks;
        pat   = '{1'b1, 1'b0, 1'b1, 1'b0};
        ticks = 0;
        for (int p = 0; p < 4; p++) begin
            sw = pat[p];
            repeat (10) begin
                @(negedge clk);
                n_checks++;
                if (db_level !== 1'b0 || db_level !== m_lvl || db_tick !== exp_tick) begin
                    n_errors++;
                    $display("FAIL bounce: level=%b tick=%b expected level=0 tick=%b",
                             db_level, db_tick, exp_tick);
                end
                if (db_tick === 1'b1) ticks++;
            end
        end
        n_checks++;
        if (ticks != 0) begin
            n_errors++;
            $display("FAIL bounce_ticks: got %0d expected 0", ticks);
        end
    endtask

    task automatic test_final_press();
        int ticks;
        ticks = 0;
        sw    = 1'b1;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            n_checks++;
            if (db_level !== m_lvl || db_tick !== exp_tick) begin
                n_errors++;
                $display("FAIL final_press cyc %0d: level=%b tick=%b expected level=%b tick=%b",
                         i, db_level, db_tick, m_lvl, exp_tick);
            end
            if (db_tick === 1'b1) ticks++;
            if (i > 51 && db_level !== 1'b1) begin
                n_errors++;
                $display("FAIL final_press_hold cyc %0d: level=%b expected 1", i, db_level);
            end
        end
        n_checks++;
        if (ticks != 1) begin
            n_errors++;
            $display("FAIL final_press_ticks: got %0d expected 1", ticks);
        end
    endtask

    task automatic test_reset_mid();
        int ticks;
        ticks = 0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (db_level !== 1'b0 || db_tick !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_async: level=%b tick=%b expected level=0 tick=0",
                     db_level, db_tick);
        end
        @(negedge clk);
        n_checks++;
        if (db_level !== 1'b0 || db_tick !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_hold: level=%b tick=%b expected level=0 tick=0",
                     db_level, db_tick);
        end
        reset = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            n_checks++;
            if (db_level !== m_lvl || db_tick !== exp_tick) begin
                n_errors++;
                $display("FAIL reset_mid_reconfirm cyc %0d: level=%b tick=%b expected %b %b",
                         i, db_level, db_tick, m_lvl, exp_tick);
            end
            if (db_tick === 1'b1) ticks++;
        end
        n_checks++;
        if (ticks != 1 || db_level !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_result: ticks=%0d level=%b expected ticks=1 level=1",
                     ticks, db_level);
        end
    endtask

    // Random low glitches shorter than the guaranteed rejection width must not drop the level.
    task automatic test_glitch_reject();
        int len;
        for (int k = 0; k < 8; k++) begin
            len = int'($urandom_range(1, 2 * PERIOD));
            sw  = 1'b0;
            repeat (len) begin
                @(negedge clk);
                n_checks++;
                if (db_level !== 1'b1 || db_tick !== 1'b0) begin
                    n_errors++;
                    $display("FAIL glitch len %0d: level=%b tick=%b expected level=1 tick=0",
                             len, db_level, db_tick);
                end
            end
            sw = 1'b1;
            repeat (40) begin
                @(negedge clk);
                n_checks++;
                if (db_level !== 1'b1 || db_tick !== 1'b0) begin
                    n_errors++;
                    $display("FAIL glitch_recover: level=%b tick=%b expected level=1 tick=0",
                             db_level, db_tick);
                end
            end
        end
    endtask

    task automatic test_random();
        int len;
        for (int k = 0; k < 30; k++) begin
            sw  = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 70));
            repeat (len) begin
                @(negedge clk);
                n_checks++;
                if (db_level !== m_lvl || db_tick !== exp_tick) begin
                    n_errors++;
                    $display("FAIL random seg %0d: level=%b tick=%b expected level=%b tick=%b",
                             k, db_level, db_tick, m_lvl, exp_tick);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_edge(1'b1, "press");
        test_edge(1'b0, "release");
        test_bounce();
        test_final_press();
        test_reset_mid();
        test_glitch_reject();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
